// File: rtl/damage_scheduler.sv
// damage_scheduler: per-tick combat sequencer; for targets 0..15 then tower (16) it sums
// attacker power on both sides and strobes the totals to the decoder. Option: SCHED_SKIP_ZERO_EN.
module damage_scheduler_side #(
  parameter int NUM_SLOTS = 16,
  parameter int TOWER_SEL = 16,
  parameter int AW        = 4
) (
  input  logic [NUM_SLOTS-1:0]   atk_valid,
  input  logic [NUM_SLOTS*5-1:0] atk_target,
  input  logic [NUM_SLOTS*8-1:0] atk_power,
  input  logic [AW-1:0]          atk,
  input  logic [4:0]             tgt,
  output logic [7:0]             add_pwr
);
  localparam logic [4:0] TOWER = 5'(TOWER_SEL);

  logic [NUM_SLOTS-1:0][4:0] code_arr;
  logic [NUM_SLOTS-1:0][7:0] pwr_arr;
  logic [4:0]                code;
  logic                      hit;

  assign code_arr = atk_target;
  assign pwr_arr  = atk_power;

  // The tower slot absorbs every code at or above the tower select.
  always_comb begin
    code    = code_arr[atk];
    hit     = atk_valid[atk] && ((tgt == TOWER) ? (code >= TOWER) : (code == tgt));
    add_pwr = hit ? pwr_arr[atk] : 8'd0;
  end
endmodule

module damage_scheduler #(
  parameter int NUM_SLOTS = 16,
  parameter int TOWER_SEL = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [15:0]  friendlyAtkValid,
  input  logic [79:0]  friendlyAtkTarget,
  input  logic [127:0] friendlyAtkPower,
  input  logic [15:0]  enemyAtkValid,
  input  logic [79:0]  enemyAtkTarget,
  input  logic [127:0] enemyAtkPower,
  output logic [4:0]   unitDamageSelect,
  output logic [11:0]  totalUnitDamage,
  output logic [4:0]   enemyDamageSelect,
  output logic [11:0]  totalEnemyDamage,
  output logic         applyStrobe,
  output logic         busy,
  output logic         done
);
  localparam int          AW       = $clog2(NUM_SLOTS);
  localparam logic [4:0]  TOWER    = 5'(TOWER_SEL);
  localparam logic [4:0]  NO_SEL   = 5'd31;
  localparam logic [AW-1:0] LAST_ATK = AW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    tgt_q, tgt_d;
  logic [AW-1:0] atk_q, atk_d;
  logic [11:0]   unit_acc_q, unit_acc_d, enemy_acc_q, enemy_acc_d;
  logic [4:0]    unit_sel_q, unit_sel_d, enemy_sel_q, enemy_sel_d;
  logic [11:0]   unit_tot_q, unit_tot_d, enemy_tot_q, enemy_tot_d;
  logic          strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;

  logic [7:0]    unit_add, enemy_add;
  logic [11:0]   unit_sum, enemy_sum;
  logic          skip;

  // Enemy attackers hurt friendly units; friendly attackers hurt the enemy side.
  damage_scheduler_side #(.NUM_SLOTS(NUM_SLOTS), .TOWER_SEL(TOWER_SEL), .AW(AW)) u_enemy_atk (
    .atk_valid (enemyAtkValid),
    .atk_target(enemyAtkTarget),
    .atk_power (enemyAtkPower),
    .atk       (atk_q),
    .tgt       (tgt_q),
    .add_pwr   (unit_add)
  );

  damage_scheduler_side #(.NUM_SLOTS(NUM_SLOTS), .TOWER_SEL(TOWER_SEL), .AW(AW)) u_friendly_atk (
    .atk_valid (friendlyAtkValid),
    .atk_target(friendlyAtkTarget),
    .atk_power (friendlyAtkPower),
    .atk       (atk_q),
    .tgt       (tgt_q),
    .add_pwr   (enemy_add)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    atk_d       = atk_q;
    unit_acc_d  = unit_acc_q;
    enemy_acc_d = enemy_acc_q;
    unit_sel_d  = NO_SEL;
    enemy_sel_d = NO_SEL;
    unit_tot_d  = 12'd0;
    enemy_tot_d = 12'd0;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // 16 x 255 fits in 12 bits, so the sums never wrap.
    unit_sum    = unit_acc_q + {4'd0, unit_add};
    enemy_sum   = enemy_acc_q + {4'd0, enemy_add};
`ifdef SCHED_SKIP_ZERO_EN
    skip        = (unit_sum == 12'd0) && (enemy_sum == 12'd0);
`else
    skip        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          tgt_d       = 5'd0;
          atk_d       = '0;
          unit_acc_d  = 12'd0;
          enemy_acc_d = 12'd0;
          busy_d      = 1'b1;
        end
      end
      SCAN: begin
        unit_acc_d  = unit_sum;
        enemy_acc_d = enemy_sum;
        atk_d       = atk_q + AW'(1);
        if (atk_q == LAST_ATK) begin
          if (!skip) begin
            state_d     = APPLY;
            strobe_d    = 1'b1;
            unit_sel_d  = tgt_q;
            enemy_sel_d = tgt_q;
            unit_tot_d  = unit_sum;
            enemy_tot_d = enemy_sum;
          end else begin
            atk_d       = '0;
            unit_acc_d  = 12'd0;
            enemy_acc_d = 12'd0;
            if (tgt_q == TOWER) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = SCAN;
              tgt_d   = tgt_q + 5'd1;
            end
          end
        end
      end
      APPLY: begin
        atk_d       = '0;
        unit_acc_d  = 12'd0;
        enemy_acc_d = 12'd0;
        if (tgt_q == TOWER) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SCAN;
          tgt_d   = tgt_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      tgt_q       <= 5'd0;
      atk_q       <= '0;
      unit_acc_q  <= 12'd0;
      enemy_acc_q <= 12'd0;
      unit_sel_q  <= NO_SEL;
      enemy_sel_q <= NO_SEL;
      unit_tot_q  <= 12'd0;
      enemy_tot_q <= 12'd0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      atk_q       <= atk_d;
      unit_acc_q  <= unit_acc_d;
      enemy_acc_q <= enemy_acc_d;
      unit_sel_q  <= unit_sel_d;
      enemy_sel_q <= enemy_sel_d;
      unit_tot_q  <= unit_tot_d;
      enemy_tot_q <= enemy_tot_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign unitDamageSelect  = unit_sel_q;
  assign totalUnitDamage   = unit_tot_q;
  assign enemyDamageSelect = enemy_sel_q;
  assign totalEnemyDamage  = enemy_tot_q;
  assign applyStrobe       = strobe_q;
  assign busy              = busy_q;
  assign done              = done_q;
endmodule

// File: doc/damage_scheduler.md
Name: damage_scheduler

Overview:
Per-game-tick combat sequencer that drives the damage decoder. On a start pulse it walks every damage target (units 0-15, then tower index 16) and sums the attack power of every attacker aimed at that target. It then presents the target select plus its 12-bit total to the decoder for one strobe cycle. Friendly attackers damage the enemy side and enemy attackers damage the friendly side; both sides are scheduled in lockstep.

Parameters:
NUM_SLOTS, 16, attackers per side and non-tower targets per side; fixed at 16 to match the 5-bit select encoding.
TOWER_SEL, 16, target code for the tower. Any attacker target code >= 16 is treated as tower.

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to run a scheduling pass; honoured only in IDLE
friendlyAtkValid  input  16  bit i = friendly attacker i attacks this tick
friendlyAtkTarget  input  80  5 bits per attacker, [5i+4:5i]; enemy target index
friendlyAtkPower  input  128  8 bits per attacker, [8i+7:8i]; unsigned damage
enemyAtkValid  input  16  bit i = enemy attacker i attacks this tick
enemyAtkTarget  input  80  5 bits per attacker; friendly target index
enemyAtkPower  input  128  8 bits per attacker
unitDamageSelect  output  5  friendly target for the decoder
totalUnitDamage  output  12  summed damage to that friendly target
enemyDamageSelect  output  5  enemy target for the decoder
totalEnemyDamage  output  12  summed damage to that enemy target
applyStrobe  output  1  high for exactly the cycles where select/total must be applied
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at pass completion

Behaviour:
- Reset (async, any state): state=IDLE, tgt=0, atk=0, both accumulators=0.
- Reset values on outputs: selects=5'd31, totals=0, applyStrobe=0, busy=0, done=0.
- All outputs are registered.
- States:
  - IDLE: start=1 -> SCAN with tgt=0, atk=0, accumulators cleared; busy rises the next cycle.
  - SCAN, one attacker index per cycle:
    - If enemyAtkValid[atk] and the enemy target matches tgt, unitAcc += enemyAtkPower[atk].
    - If friendlyAtkValid[atk] and the friendly target matches tgt, enemyAcc += friendlyAtkPower[atk].
    - Match rule: target code == tgt for tgt<16. For tgt==16, any code >= 16 matches.
    - atk==15 -> APPLY.
  - APPLY, one cycle:
    - applyStrobe=1, unitDamageSelect=enemyDamageSelect=tgt, totalUnitDamage=unitAcc, totalEnemyDamage=enemyAcc.
    - Next cycle: accumulators cleared, atk=0.
    - If tgt<16: tgt++ and go to SCAN.
    - If tgt==16: go to DONE.
  - DONE, one cycle: done=1, busy=0 next cycle, then IDLE.
- Outside APPLY: selects=5'd31, totals=0, applyStrobe=0. The decoder therefore sees zero damage routed to the tower.
- Accumulators are 12 bits. The maximum is 16x255=4080, so they never overflow and no saturation logic is needed; the decoder saturates to 8 bits.
- Pass timing, counting start accepted at cycle 0:
  - 17 x (16 scan + 1 apply) = 289 cycles.
  - First applyStrobe at cycle 17 (tgt 0); last at cycle 289 (tgt 16).
  - done at cycle 290.
- Attacker buses are sampled live each SCAN cycle. Upstream holds them stable while busy=1. A change mid-pass affects only attackers not yet scanned for the current target.
- start while busy or in DONE is ignored; no queueing.
- start and Reset together: Reset wins.
- Reset asserted mid-pass aborts with no further strobes or done. The next pass starts fresh.

Optional Feature:
Macro SCHED_SKIP_ZERO_EN.
- Defined: at the end of a target's scan, if both accumulators are 0, skip APPLY (no strobe) and advance directly. Each skipped target saves one cycle. If tgt==16 also has zero damage, go straight to DONE.
- Not defined: every target gets an APPLY cycle, so the pass is always exactly 289 cycles plus the DONE cycle.

Test Plan:
1. Reset mid-SCAN (tgt=5) -> outputs return to reset values immediately; no done; a new start runs a full 290-cycle pass.
2. All valids 0, start -> 17 strobes with totals 0 at cycles 17, 34, ..., 289; done at 290.
   - With SCHED_SKIP_ZERO_EN: no strobes, done at cycle 273.
3. Enemy attackers 0, 3 and 15 target friendly unit 7 with powers 10, 20 and 200 -> on the tgt=7 strobe, unitDamageSelect=7 and totalUnitDamage=230; every other strobe has totalUnitDamage=0.
4. All 16 friendly attackers target enemy code 20 (tower) with power 255 -> on the tgt=16 strobe, enemyDamageSelect=16 and totalEnemyDamage=4080; no other enemy strobe is nonzero.
5. start pulsed again at cycles 50 and 290 -> both ignored; busy stays high until done; no second pass begins.
6. Friendly attacker 2 targets enemy 4 (power 9) and enemy attacker 2 targets unit 4 (power 6), valids otherwise 0 -> the tgt=4 strobe carries totalEnemyDamage=9 and totalUnitDamage=6 in the same cycle.
